// File: rtl/ng_clk_ctl.sv
// Run/step sequencer for the AGC two-phase clock generator: drives MCLK/FCLK/CLK_SEL/CLK_SLOW
// from panel controls, with a slow-clock prescaler and a debounced step button.
module ng_clk_ctl #(
  parameter int SLOW_DIV = 1000000,
  parameter int DEB_CYC  = 20000,
  parameter int PULSE_W  = 4,
  parameter int CNT_W    = 16
) (
  input  logic             CLK_2MHZ,
  input  logic             PURST,
  input  logic             RUN_REQ,
  input  logic             HALT_REQ,
  input  logic             BRK,
  input  logic             STEP_BTN,
  input  logic             BURST_GO,
  input  logic [CNT_W-1:0] BURST_N,
  input  logic             SLOW_MODE,
  output logic             MCLK,
  output logic             FCLK,
  output logic             CLK_SEL,
  output logic             CLK_SLOW,
  output logic             RUNNING,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       HALT_CAUSE,
  output logic [CNT_W-1:0] STEPS_LEFT
);

  localparam int PRE_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int PW_W  = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] STEP     = 3'd1;
  localparam logic [2:0] BURST_HI = 3'd2;
  localparam logic [2:0] BURST_LO = 3'd3;
  localparam logic [2:0] RUN      = 3'd4;

  logic [PRE_W-1:0] pre_cnt;
  logic             btn_s1, btn_s2, btn_s3, deb_lvl, step_ev;
  logic [DEB_W-1:0] deb_cnt;
  logic [2:0]       state;
  logic [PW_W-1:0]  pcnt;
  logic             abort;
  logic             pulse_end;
  logic             stop_req;

  assign pulse_end = (pcnt == PW_W'(PULSE_W - 1));
  assign stop_req  = HALT_REQ | BRK;

  always_ff @(posedge CLK_2MHZ) begin
    if (PURST) begin
      pre_cnt  <= '0;
      CLK_SLOW <= 1'b0;
    end else if (pre_cnt == PRE_W'(SLOW_DIV - 1)) begin
      pre_cnt  <= '0;
      CLK_SLOW <= ~CLK_SLOW;
    end else begin
      pre_cnt  <= pre_cnt + PRE_W'(1);
    end
  end

  // Stable-count restarts whenever the synchronized level changes; it saturates once
  // the level has been accepted, so a held button yields a single step event.
  always_ff @(posedge CLK_2MHZ) begin
    if (PURST) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      btn_s3  <= 1'b0;
      deb_lvl <= 1'b0;
      deb_cnt <= '0;
      step_ev <= 1'b0;
    end else begin
      btn_s1  <= STEP_BTN;
      btn_s2  <= btn_s1;
      btn_s3  <= btn_s2;
      step_ev <= 1'b0;
      if (btn_s2 != btn_s3) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_W'(DEB_CYC - 1)) begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end else if (deb_lvl != btn_s2) begin
        deb_lvl <= btn_s2;
        step_ev <= btn_s2;
      end
    end
  end

  always_ff @(posedge CLK_2MHZ) begin
    if (PURST) begin
      state      <= IDLE;
      MCLK       <= 1'b0;
      FCLK       <= 1'b0;
      CLK_SEL    <= 1'b0;
      RUNNING    <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      HALT_CAUSE <= 2'd0;
      STEPS_LEFT <= '0;
      pcnt       <= '0;
      abort      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          CLK_SEL <= SLOW_MODE;
          // HALT_REQ outranks every start request, including RUN_REQ.
          if (!HALT_REQ) begin
            if (RUN_REQ) begin
              state      <= RUN;
              FCLK       <= 1'b1;
              RUNNING    <= 1'b1;
              BUSY       <= 1'b1;
              HALT_CAUSE <= 2'd0;
            end else if (BURST_GO) begin
              if (BURST_N != '0) begin
                state      <= BURST_HI;
                MCLK       <= 1'b1;
                BUSY       <= 1'b1;
                STEPS_LEFT <= BURST_N;
                pcnt       <= '0;
                abort      <= 1'b0;
              end
            end else if (step_ev) begin
              state <= STEP;
              MCLK  <= 1'b1;
              BUSY  <= 1'b1;
              pcnt  <= '0;
            end
          end
        end
        STEP: begin
          if (pulse_end) begin
            state <= IDLE;
            MCLK  <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            pcnt <= pcnt + PW_W'(1);
          end
        end
        BURST_HI: begin
          if (stop_req) abort <= 1'b1;
          if (pulse_end) begin
            state      <= BURST_LO;
            MCLK       <= 1'b0;
            STEPS_LEFT <= STEPS_LEFT - CNT_W'(1);
            pcnt       <= '0;
          end else begin
            pcnt <= pcnt + PW_W'(1);
          end
        end
        BURST_LO: begin
          if (pulse_end) begin
            pcnt <= '0;
            if (abort || stop_req) begin
              state      <= IDLE;
              BUSY       <= 1'b0;
              HALT_CAUSE <= 2'd3;
              abort      <= 1'b0;
            end else if (STEPS_LEFT == '0) begin
              state <= IDLE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end else begin
              state <= BURST_HI;
              MCLK  <= 1'b1;
            end
          end else begin
            if (stop_req) abort <= 1'b1;
            pcnt <= pcnt + PW_W'(1);
          end
        end
        RUN: begin
          if (stop_req) begin
            state      <= IDLE;
            FCLK       <= 1'b0;
            RUNNING    <= 1'b0;
            BUSY       <= 1'b0;
            HALT_CAUSE <= BRK ? 2'd2 : 2'd1;
          end
        end
        default: begin
          state   <= IDLE;
          MCLK    <= 1'b0;
          FCLK    <= 1'b0;
          RUNNING <= 1'b0;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ng_clk_ctl.sv
// Directed self-checking bench for ng_clk_ctl with small divider/debounce/pulse parameters.
module tb_ng_clk_ctl;

  logic        clk = 1'b0;
  logic        purst, run_req, halt_req, brk, step_btn, burst_go, slow_mode;
  logic [15:0] burst_n;
  logic        mclk, fclk, clk_sel, clk_slow, running, busy, done;
  logic [1:0]  halt_cause;
  logic [15:0] steps_left;

  int compared   = 0;
  int mismatched = 0;

  int   hi_cnt, rises, done_cnt, last_hi, done_at, first_rise, tick_idx;
  logic prev_m;

  int exp_m  [13] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0};
  int exp_sl [13] = '{3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0};
  int exp_dn [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  ng_clk_ctl #(.SLOW_DIV(4), .DEB_CYC(3), .PULSE_W(2), .CNT_W(16)) dut (
    .CLK_2MHZ  (clk),
    .PURST     (purst),
    .RUN_REQ   (run_req),
    .HALT_REQ  (halt_req),
    .BRK       (brk),
    .STEP_BTN  (step_btn),
    .BURST_GO  (burst_go),
    .BURST_N   (burst_n),
    .SLOW_MODE (slow_mode),
    .MCLK      (mclk),
    .FCLK      (fclk),
    .CLK_SEL   (clk_sel),
    .CLK_SLOW  (clk_slow),
    .RUNNING   (running),
    .BUSY      (busy),
    .DONE      (done),
    .HALT_CAUSE(halt_cause),
    .STEPS_LEFT(steps_left)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic btn_phase(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      step_btn = b;
      tick();
      if (mclk) begin
        hi_cnt++;
        last_hi = tick_idx;
        if (!prev_m) begin
          rises++;
          if (first_rise < 0) first_rise = tick_idx;
        end
      end
      if (done) begin
        done_cnt++;
        done_at = tick_idx;
      end
      prev_m = mclk;
      tick_idx++;
    end
  endtask

  initial begin
    purst = 1'b1; run_req = 1'b0; halt_req = 1'b0; brk = 1'b0;
    step_btn = 1'b0; burst_go = 1'b0; slow_mode = 1'b0; burst_n = '0;
    tick();
    tick();
    purst = 1'b0;
    chk("rst_mclk",  32'(mclk), 0);
    chk("rst_fclk",  32'(fclk), 0);
    chk("rst_sel",   32'(clk_sel), 0);
    chk("rst_slow",  32'(clk_slow), 0);
    chk("rst_run",   32'(running), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_cause", 32'(halt_cause), 0);
    chk("rst_left",  32'(steps_left), 0);

    // Prescaler: toggle every 4 cycles
    tick(); tick(); tick();
    chk("slow_3", 32'(clk_slow), 0);
    tick();
    chk("slow_4", 32'(clk_slow), 1);
    tick(); tick(); tick();
    chk("slow_7", 32'(clk_slow), 1);
    tick();
    chk("slow_8", 32'(clk_slow), 0);

    // Bouncy step button, then a long hold and release
    hi_cnt = 0; rises = 0; done_cnt = 0; last_hi = -10; done_at = -1;
    first_rise = -1; tick_idx = 0; prev_m = 1'b0;
    btn_phase(1'b1, 1); btn_phase(1'b0, 1); btn_phase(1'b1, 2); btn_phase(1'b0, 1);
    btn_phase(1'b1, 1); btn_phase(1'b0, 2); btn_phase(1'b1, 2); btn_phase(1'b0, 1);
    btn_phase(1'b1, 50);
    btn_phase(1'b0, 10);
    chk("step_rises",    32'(rises), 1);
    chk("step_hi_width", 32'(hi_cnt), 2);
    chk("step_after_bounce", 32'(first_rise >= 11), 1);
    chk("step_done_cnt", 32'(done_cnt), 1);
    chk("step_done_pos", 32'(done_at), 32'(last_hi + 1));
    chk("step_busy",     32'(busy), 0);

    // Burst of 3
    burst_n = 16'd3; burst_go = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      burst_go = 1'b0;
      chk($sformatf("b3_mclk[%0d]", i), 32'(mclk), exp_m[i]);
      chk($sformatf("b3_left[%0d]", i), 32'(steps_left), exp_sl[i]);
      chk($sformatf("b3_done[%0d]", i), 32'(done), exp_dn[i]);
    end
    chk("b3_busy_end", 32'(busy), 0);
    tick();
    chk("b3_done_1cyc", 32'(done), 0);

    // Burst of 0: no action
    burst_n = 16'd0; burst_go = 1'b1;
    tick();
    burst_go = 1'b0;
    chk("b0_busy", 32'(busy), 0);
    chk("b0_mclk", 32'(mclk), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("b0_done[%0d]", i), 32'(done | mclk), 0);
    end

    // Burst of 5 aborted by HALT_REQ during the second high pulse
    chk("ab_cause_pre", 32'(halt_cause), 0);
    burst_n = 16'd5; burst_go = 1'b1;
    tick(); burst_go = 1'b0;               // idx 0
    tick(); tick(); tick();                // idx 3
    tick();                                // idx 4: second pulse starts
    chk("ab_mclk4", 32'(mclk), 1);
    halt_req = 1'b1;
    tick();                                // idx 5
    halt_req = 1'b0;
    chk("ab_mclk5_full", 32'(mclk), 1);
    tick();                                // idx 6
    chk("ab_mclk6", 32'(mclk), 0);
    chk("ab_left6", 32'(steps_left), 3);
    tick();                                // idx 7
    chk("ab_busy7", 32'(busy), 1);
    tick();                                // idx 8
    chk("ab_busy8",  32'(busy), 0);
    chk("ab_cause",  32'(halt_cause), 3);
    chk("ab_left",   32'(steps_left), 3);
    chk("ab_done",   32'(done), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ab_quiet[%0d]", i), 32'(done | mclk), 0);
    end

    // RUN_REQ with HALT_REQ in IDLE stays idle
    run_req = 1'b1; halt_req = 1'b1;
    tick();
    run_req = 1'b0; halt_req = 1'b0;
    chk("rh_idle_busy", 32'(busy), 0);
    chk("rh_idle_fclk", 32'(fclk), 0);

    // Slow-mode run; CLK_SEL frozen while running
    slow_mode = 1'b1;
    tick();
    chk("run_sel_load", 32'(clk_sel), 1);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    chk("run_fclk",    32'(fclk), 1);
    chk("run_running", 32'(running), 1);
    chk("run_busy",    32'(busy), 1);
    chk("run_mclk",    32'(mclk), 0);
    chk("run_cause0",  32'(halt_cause), 0);
    slow_mode = 1'b0;
    tick(); tick(); tick();
    chk("run_sel_hold", 32'(clk_sel), 1);
    chk("run_fclk_hold", 32'(fclk), 1);

    // HALT_REQ and BRK together: BRK wins
    halt_req = 1'b1; brk = 1'b1;
    tick();
    halt_req = 1'b0; brk = 1'b0;
    chk("hb_fclk",  32'(fclk), 0);
    chk("hb_run",   32'(running), 0);
    chk("hb_cause", 32'(halt_cause), 2);
    tick();
    chk("hb_sel_reload", 32'(clk_sel), 0);

    // HALT_REQ alone from RUN
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    chk("h_run_fclk", 32'(fclk), 1);
    chk("h_run_cause0", 32'(halt_cause), 0);
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("h_fclk",  32'(fclk), 0);
    chk("h_cause", 32'(halt_cause), 1);
    chk("h_busy",  32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ng_clk_ctl.md
Name: ng_clk_ctl

Overview:
- Run/step sequencer for the AGC two-phase clock generator. Drives that generator's MCLK, FCLK, CLK_SEL and CLK_SLOW inputs from panel controls.
- Supported modes: halted, single manual step, counted burst of N steps, and free run at 2 MHz or slow rate.
- Sits between the front-panel/debug interface and the clock generator. Also generates the slow clock and debounces the step button.

Parameters:
- SLOW_DIV, 1000000: CLK_2MHZ cycles per CLK_SLOW half-period (1 Hz at 2 MHz).
- DEB_CYC, 20000: cycles STEP_BTN must be stable before a level change is accepted (10 ms).
- PULSE_W, 4: cycles MCLK is high, and minimum low time between burst pulses.
- CNT_W, 16: width of the burst step counter.

Ports:
- CLK_2MHZ  in  1  system clock; all logic on its rising edge.
- PURST  in  1  synchronous, active-high reset.
- RUN_REQ  in  1  level; request free run.
- HALT_REQ  in  1  level; request halt.
- BRK  in  1  1-cycle pulse; breakpoint hit, halts run or burst.
- STEP_BTN  in  1  raw asynchronous push button, active high.
- BURST_GO  in  1  1-cycle pulse; start a burst of BURST_N steps.
- BURST_N  in  CNT_W  burst length; sampled on BURST_GO.
- SLOW_MODE  in  1  1 = free run from CLK_SLOW, 0 = from 2 MHz.
- MCLK  out  1  manual clock pulse to the clock generator.
- FCLK  out  1  fast/free-run enable to the clock generator.
- CLK_SEL  out  1  clock-select to the clock generator.
- CLK_SLOW  out  1  divided square wave.
- RUNNING  out  1  high in RUN state.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  1-cycle pulse when STEP or BURST completes normally.
- HALT_CAUSE  out  2  cause of the last halt: 0 none, 1 HALT_REQ, 2 BRK, 3 burst aborted.
- STEPS_LEFT  out  CNT_W  remaining burst pulses.

Behaviour:
- Reset (PURST=1 at a clock edge):
  - State IDLE.
  - MCLK, FCLK, CLK_SEL, CLK_SLOW, RUNNING, BUSY, DONE = 0.
  - HALT_CAUSE = 0, STEPS_LEFT = 0.
  - Divider, debouncer and pulse counters cleared.
  - Reset mid-pulse truncates MCLK; this is allowed only for reset.
- Outputs: all are registered; no combinational paths from inputs to outputs.
- Prescaler:
  - Free-running counter 0..SLOW_DIV-1.
  - CLK_SLOW toggles when the counter wraps, giving a period of 2*SLOW_DIV cycles.
  - Runs in every state.
- Debouncer:
  - STEP_BTN passes through a 2-flop synchronizer.
  - A stable-count counter resets on any change of the synchronized value.
  - The debounced level updates after DEB_CYC equal samples.
  - A step event is the debounced 0->1 edge. One event per press, no matter how long the button is held.
- CLK_SEL: loaded from SLOW_MODE only while in IDLE, so it never changes during RUN or a pulse.
- FSM states: IDLE, STEP, BURST_HI, BURST_LO, RUN.
- IDLE (FCLK=0, MCLK=0). Checks in priority order:
  - HALT_REQ: stay in IDLE.
  - RUN_REQ: go to RUN and clear HALT_CAUSE.
  - BURST_GO with BURST_N != 0: load STEPS_LEFT=BURST_N, go to BURST_HI.
  - BURST_GO with BURST_N == 0: no action, DONE=0.
  - Step event: go to STEP.
  - Events arriving outside IDLE are dropped.
- STEP:
  - MCLK=1 for exactly PULSE_W cycles.
  - Then IDLE, with DONE=1 for one cycle.
  - HALT_REQ or BRK is ignored until the pulse completes.
- BURST_HI:
  - MCLK=1 for PULSE_W cycles.
  - On leaving, decrement STEPS_LEFT and go to BURST_LO.
- BURST_LO:
  - MCLK=0 for PULSE_W cycles.
  - If STEPS_LEFT = 0: go to IDLE with DONE=1.
  - Otherwise: go to BURST_HI.
- Abort during a burst (HALT_REQ or BRK in BURST_HI or BURST_LO):
  - Latched into an abort flag; the current high pulse is never shortened.
  - At the end of the current BURST_LO, go to IDLE with HALT_CAUSE=3 (abort) and no DONE.
  - STEPS_LEFT keeps the remaining count.
- RUN (FCLK=1, MCLK=0, RUNNING=1):
  - HALT_REQ: IDLE next cycle, HALT_CAUSE=1.
  - BRK: IDLE next cycle, HALT_CAUSE=2.
  - HALT_REQ and BRK in the same cycle: HALT_CAUSE=2 (BRK wins).
- RUN_REQ and HALT_REQ both high in IDLE: remain in IDLE.
- Burst length: a burst of N yields exactly N MCLK pulses and takes 2*N*PULSE_W cycles from the BURST_GO cycle+1 to DONE.

Test Plan (SLOW_DIV=4, DEB_CYC=3, PULSE_W=2):
- Reset: hold PURST 2 cycles -> all outputs 0, state IDLE, CLK_SLOW starts toggling every 4 cycles afterwards.
- Bouncy STEP_BTN (0/1 glitches shorter than 3 cycles, then held high for 50 cycles) -> exactly one MCLK pulse 2 cycles wide, then DONE pulse, BUSY back to 0.
- BURST_GO with BURST_N=3 -> 3 MCLK pulses (2 high / 2 low), STEPS_LEFT 3->2->1->0, DONE 12 cycles after GO+1; repeat with BURST_N=0 -> no pulse, no DONE.
- Abort: BURST_N=5, HALT_REQ asserted during the second high pulse -> that pulse still lasts 2 cycles, then IDLE, HALT_CAUSE=3, STEPS_LEFT=3, no DONE.
- SLOW_MODE=1 then RUN_REQ -> CLK_SEL=1, FCLK=1, RUNNING=1; toggle SLOW_MODE while running -> CLK_SEL unchanged.
- RUN with HALT_REQ and BRK in the same cycle -> FCLK=0 next cycle, HALT_CAUSE=2.
